// File: rtl/s_mem_pkg.sv
// ----------------------------------------------------------------------------
// s_mem_pkg: shared types and constants for the S-array memory responder.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package s_mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int S_DEPTH    = 256;
  // Wide enough for the largest legal RD_LAT-1 load value (2).
  localparam int CNT_W      = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_EXEC = 3'd1,
    ST_WR_ACK  = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_RD_ACK  = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/s_mem_lat_counter.sv
// ----------------------------------------------------------------------------
// s_mem_lat_counter: load/decrement down-counter with a zero flag.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module s_mem_lat_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/s_mem_responder.sv
// ----------------------------------------------------------------------------
// s_mem_responder: wr/rd start-done handshake responder driving a 256x8 RAM.
// Optional protocol checker: define S_MEM_PROTOCOL_CHECK_EN. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module s_mem_responder
  import s_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_start,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wr_data_in,
  output logic              wr_done,
  output logic              rd_done,
  output logic [DATA_W-1:0] rd_data_out,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              proto_err
);

  localparam logic [CNT_W-1:0] C_LAT_LOAD = CNT_W'(RD_LAT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_data;
  logic              r_ram_wren;
  logic [DATA_W-1:0] r_rd_data;
  logic              w_busy;
  logic              w_wr_done;
  logic              w_rd_done;
  logic              w_accept_wr;
  logic              w_accept_rd;
  logic              w_cnt_load;
  logic              w_cnt_dec;
  logic              w_cnt_zero;
  logic              w_capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        // Write has priority over a simultaneous read.
        if (wr_start)      w_state_nxt = ST_WR_EXEC;
        else if (rd_start) w_state_nxt = ST_RD_ADDR;
      end
      ST_WR_EXEC: w_state_nxt = ST_WR_ACK;
      ST_WR_ACK:  w_state_nxt = ST_IDLE;
      ST_RD_ADDR: w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: if (w_cnt_zero) w_state_nxt = ST_RD_ACK;
      ST_RD_ACK:  w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy      = (r_state != ST_IDLE);
    w_wr_done   = (r_state == ST_WR_ACK);
    w_rd_done   = (r_state == ST_RD_ACK);
    w_accept_wr = (r_state == ST_IDLE) && wr_start;
    w_accept_rd = (r_state == ST_IDLE) && rd_start && !wr_start;
    w_cnt_load  = (r_state == ST_RD_ADDR);
    w_cnt_dec   = (r_state == ST_RD_WAIT) && !w_cnt_zero;
    w_capture   = (r_state == ST_RD_WAIT) && w_cnt_zero;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ram_wren <= 1'b0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_rd_data  <= '0;
    end else begin
      r_ram_wren <= w_accept_wr;
      if (w_accept_wr || w_accept_rd) r_ram_addr <= addr_in;
      if (w_accept_wr)                r_ram_data <= wr_data_in;
      if (w_capture)                  r_rd_data  <= ram_q;
    end
  end

  s_mem_lat_counter #(
    .WIDTH(CNT_W)
  ) u_lat_cnt (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_cnt_load),
    .i_load_val(C_LAT_LOAD),
    .i_dec     (w_cnt_dec),
    .o_zero    (w_cnt_zero)
  );

`ifdef S_MEM_PROTOCOL_CHECK_EN
  logic r_proto_err;
  logic w_proto_viol;

  // Every done cycle is also a busy cycle, so start-during-done is covered.
  assign w_proto_viol = (wr_start && rd_start) || ((wr_start || rd_start) && w_busy);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_proto_err <= 1'b0;
    end else if (w_proto_viol) begin
      r_proto_err <= 1'b1;
    end
  end

  assign proto_err = r_proto_err;
`else
  assign proto_err = 1'b0;
`endif

  assign wr_done     = w_wr_done;
  assign rd_done     = w_rd_done;
  assign busy        = w_busy;
  assign ram_addr    = r_ram_addr;
  assign ram_data    = r_ram_data;
  assign ram_wren    = r_ram_wren;
  assign rd_data_out = r_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_s_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_s_mem_responder: directed bench for s_mem_responder (RD_LAT=1 and RD_LAT=3).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_s_mem_responder;

`ifdef S_MEM_PROTOCOL_CHECK_EN
  localparam bit PE_ON = 1'b1;
`else
  localparam bit PE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance A: RD_LAT=1
  logic       a_wr_start = 0, a_rd_start = 0;
  logic [7:0] a_addr_in = 0, a_wr_data_in = 0;
  logic       a_wr_done, a_rd_done, a_busy, a_ram_wren, a_proto_err;
  logic [7:0] a_rd_data_out, a_ram_addr, a_ram_data, a_ram_q;
  // Instance B: RD_LAT=3
  logic       b_wr_start = 0, b_rd_start = 0;
  logic [7:0] b_addr_in = 0, b_wr_data_in = 0;
  logic       b_wr_done, b_rd_done, b_busy, b_ram_wren, b_proto_err;
  logic [7:0] b_rd_data_out, b_ram_addr, b_ram_data, b_ram_q;

  s_mem_responder #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) u_dut_a (
    .clk(clk), .reset(reset), .wr_start(a_wr_start), .rd_start(a_rd_start),
    .addr_in(a_addr_in), .wr_data_in(a_wr_data_in), .wr_done(a_wr_done),
    .rd_done(a_rd_done), .rd_data_out(a_rd_data_out), .busy(a_busy),
    .ram_addr(a_ram_addr), .ram_data(a_ram_data), .ram_wren(a_ram_wren),
    .ram_q(a_ram_q), .proto_err(a_proto_err)
  );

  s_mem_responder #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3)) u_dut_b (
    .clk(clk), .reset(reset), .wr_start(b_wr_start), .rd_start(b_rd_start),
    .addr_in(b_addr_in), .wr_data_in(b_wr_data_in), .wr_done(b_wr_done),
    .rd_done(b_rd_done), .rd_data_out(b_rd_data_out), .busy(b_busy),
    .ram_addr(b_ram_addr), .ram_data(b_ram_data), .ram_wren(b_ram_wren),
    .ram_q(b_ram_q), .proto_err(b_proto_err)
  );

  // RAM models: A samples address at the edge and returns q one cycle later,
  // B passes the read through a three-stage pipeline.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] b_p1, b_p2;
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
  end
  always @(posedge clk) begin
    if (a_ram_wren) mem_a[a_ram_addr] <= a_ram_data;
    a_ram_q <= mem_a[a_ram_addr];
    if (b_ram_wren) mem_b[b_ram_addr] <= b_ram_data;
    b_p1    <= mem_b[b_ram_addr];
    b_p2    <= b_p1;
    b_ram_q <= b_p2;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge: applies one start pulse, then watches 6 cycles.
  task automatic run_op(input bit use_b, input bit wr, input bit rd,
                        input logic [7:0] a, input logic [7:0] d,
                        output int wr_cnt, output int rd_cnt,
                        output int wr_at, output int rd_at);
    wr_cnt = 0; rd_cnt = 0; wr_at = -1; rd_at = -1;
    if (use_b) begin
      b_wr_start = wr; b_rd_start = rd; b_addr_in = a; b_wr_data_in = d;
    end else begin
      a_wr_start = wr; a_rd_start = rd; a_addr_in = a; a_wr_data_in = d;
    end
    @(negedge clk);
    a_wr_start = 0; a_rd_start = 0; b_wr_start = 0; b_rd_start = 0;
    for (int c = 1; c <= 6; c++) begin
      if (use_b ? b_wr_done : a_wr_done) begin wr_cnt++; wr_at = c; end
      if (use_b ? b_rd_done : a_rd_done) begin rd_cnt++; rd_at = c; end
      if (c < 6) @(negedge clk);
    end
    @(negedge clk);
  endtask

  typedef struct {
    bit         wr;
    bit         rd;
    logic [7:0] addr;
    logic [7:0] data;
    int         exp_wr_at;  // -1: no wr_done expected
    int         exp_rd_at;  // -1: no rd_done expected
    logic [7:0] exp_rd_data;
    bit         exp_pe;
  } vec_t;

  vec_t vecs [9];

  int wc, rc, wa, ra, tmo;

  initial begin
    vecs[0] = '{1, 0, 8'h2A, 8'h5C,  2, -1, 8'h00, 1'b0};
    vecs[1] = '{0, 1, 8'h2A, 8'h00, -1,  3, 8'h5C, 1'b0};
    vecs[2] = '{1, 0, 8'h00, 8'h11,  2, -1, 8'h5C, 1'b0};
    vecs[3] = '{1, 0, 8'hFF, 8'hEE,  2, -1, 8'h5C, 1'b0};
    vecs[4] = '{0, 1, 8'h00, 8'h00, -1,  3, 8'h11, 1'b0};
    vecs[5] = '{0, 1, 8'hFF, 8'h00, -1,  3, 8'hEE, 1'b0};
    vecs[6] = '{1, 1, 8'h10, 8'hAA,  2, -1, 8'hEE, PE_ON};
    vecs[7] = '{0, 1, 8'h10, 8'h00, -1,  3, 8'hAA, PE_ON};
    vecs[8] = '{0, 1, 8'h2A, 8'h00, -1,  3, 8'h5C, PE_ON};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_busy",     32'(a_busy),        0);
    chk("rst_wr_done",  32'(a_wr_done),     0);
    chk("rst_rd_done",  32'(a_rd_done),     0);
    chk("rst_ram_wren", 32'(a_ram_wren),    0);
    chk("rst_ram_addr", 32'(a_ram_addr),    0);
    chk("rst_ram_data", 32'(a_ram_data),    0);
    chk("rst_rd_data",  32'(a_rd_data_out), 0);
    chk("rst_proto",    32'(a_proto_err),   0);

    // Cycle-accurate write of 0x5C to 0x2A
    a_wr_start = 1; a_addr_in = 8'h2A; a_wr_data_in = 8'h5C;
    @(negedge clk);
    a_wr_start = 0; a_addr_in = 8'h00; a_wr_data_in = 8'h00;
    chk("wr_c1_wren", 32'(a_ram_wren), 1);
    chk("wr_c1_addr", 32'(a_ram_addr), 32'h2A);
    chk("wr_c1_data", 32'(a_ram_data), 32'h5C);
    chk("wr_c1_busy", 32'(a_busy),     1);
    chk("wr_c1_done", 32'(a_wr_done),  0);
    @(negedge clk);
    chk("wr_c2_wren", 32'(a_ram_wren), 0);
    chk("wr_c2_done", 32'(a_wr_done),  1);
    chk("wr_c2_busy", 32'(a_busy),     1);
    @(negedge clk);
    chk("wr_c3_done", 32'(a_wr_done),  0);
    chk("wr_c3_busy", 32'(a_busy),     0);
    chk("wr_c3_addr_hold", 32'(a_ram_addr), 32'h2A);

    // Table-driven operations on instance A
    for (int i = 0; i < 9; i++) begin
      run_op(0, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, wc, rc, wa, ra);
      chk($sformatf("v%0d_wr_cnt", i), 32'(wc), (vecs[i].exp_wr_at >= 0) ? 1 : 0);
      chk($sformatf("v%0d_rd_cnt", i), 32'(rc), (vecs[i].exp_rd_at >= 0) ? 1 : 0);
      chk($sformatf("v%0d_wr_at", i),  32'(wa), 32'(vecs[i].exp_wr_at));
      chk($sformatf("v%0d_rd_at", i),  32'(ra), 32'(vecs[i].exp_rd_at));
      chk($sformatf("v%0d_rd_data", i), 32'(a_rd_data_out), 32'(vecs[i].exp_rd_data));
      chk($sformatf("v%0d_proto", i),  32'(a_proto_err), 32'(vecs[i].exp_pe));
    end

    // Second rd_start during cycle 1 of a read is ignored
    a_rd_start = 1; a_addr_in = 8'hFF;
    @(negedge clk);
    a_addr_in = 8'h00;
    wc = 0; rc = 0;
    for (int c = 1; c <= 6; c++) begin
      if (a_rd_done) rc++;
      if (a_wr_done) wc++;
      a_rd_start = (c == 1);
      @(negedge clk);
    end
    a_rd_start = 0;
    chk("rerd_rd_cnt",  32'(rc), 1);
    chk("rerd_wr_cnt",  32'(wc), 0);
    chk("rerd_data",    32'(a_rd_data_out), 32'hEE);
    chk("rerd_addr",    32'(a_ram_addr), 32'hFF);
    chk("rerd_proto",   32'(a_proto_err), 32'(PE_ON));

    // RD_LAT=3 instance: write then read, done at start+5
    run_op(1, 1, 0, 8'h2A, 8'h5C, wc, rc, wa, ra);
    chk("b_wr_at", 32'(wa), 2);
    run_op(1, 0, 1, 8'h2A, 8'h00, wc, rc, wa, ra);
    chk("b_rd_cnt",  32'(rc), 1);
    chk("b_rd_at",   32'(ra), 5);
    chk("b_rd_data", 32'(b_rd_data_out), 32'h5C);

    // Reset asserted during WR_EXEC
    a_wr_start = 1; a_addr_in = 8'h77; a_wr_data_in = 8'h99;
    @(negedge clk);
    a_wr_start = 0;
    chk("rstmid_wren_before", 32'(a_ram_wren), 1);
    reset = 1'b1;
    #1;
    chk("rstmid_wren", 32'(a_ram_wren), 0);
    chk("rstmid_busy", 32'(a_busy),     0);
    @(negedge clk);
    reset = 1'b0;
    wc = 0;
    for (int c = 0; c < 4; c++) begin
      if (a_wr_done) wc++;
      @(negedge clk);
    end
    chk("rstmid_no_done", 32'(wc), 0);
    chk("rstmid_proto",   32'(a_proto_err), 0);
    run_op(0, 1, 0, 8'h01, 8'h33, wc, rc, wa, ra);
    chk("post_rst_wr_at", 32'(wa), 2);
    run_op(0, 0, 1, 8'h01, 8'h00, wc, rc, wa, ra);
    chk("post_rst_rd_data", 32'(a_rd_data_out), 32'h33);
    chk("post_rst_unwritten", 32'(mem_a[8'h77]), 0);

    // Back-to-back sweep: each start issued the cycle after the previous done
    wc = 0;
    for (int i = 0; i < 256; i++) begin
      a_wr_start = 1; a_addr_in = 8'(i); a_wr_data_in = 8'(i);
      @(negedge clk);
      a_wr_start = 0;
      tmo = 0;
      while (!a_wr_done && tmo < 10) begin @(negedge clk); tmo++; end
      if (a_wr_done) wc++;
      @(negedge clk);
    end
    chk("sweep_wr_done_cnt", 32'(wc), 256);
    rc = 0;
    for (int i = 0; i < 256; i++) begin
      a_rd_start = 1; a_addr_in = 8'(i);
      @(negedge clk);
      a_rd_start = 0;
      tmo = 0;
      while (!a_rd_done && tmo < 10) begin @(negedge clk); tmo++; end
      if (a_rd_done) rc++;
      if (i == 0 || i == 255 || a_rd_data_out !== 8'(i))
        chk($sformatf("sweep_rd_%0d", i), 32'(a_rd_data_out), 32'(i));
      @(negedge clk);
    end
    chk("sweep_rd_done_cnt", 32'(rc), 256);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/s_mem_responder.md
Name: s_mem_responder

Overview:
- Responder end of the single-client S-array memory handshake (wr_start/wr_done, rd_start/rd_done).
- Accepts one read or write request per handshake from a client FSM (init, shuffle, decrypt) and drives a synchronous single-port 256x8 on-chip RAM.
- Returns a one-cycle done pulse when the request completes; read data accompanies rd_done.
- Sits between the client FSM mux and the S-array RAM instance.

Parameters:
- ADDR_W, 8, address width (RAM depth 2^ADDR_W)
- DATA_W, 8, data width
- RD_LAT, 1, RAM read latency in cycles from address-registered to q valid; legal range 1..3

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- wr_start  in  1  one-cycle write request pulse
- rd_start  in  1  one-cycle read request pulse
- addr_in  in  ADDR_W  request address, sampled on the start cycle
- wr_data_in  in  DATA_W  write data, sampled on wr_start cycle
- wr_done  out  1  one-cycle pulse, write committed
- rd_done  out  1  one-cycle pulse, rd_data_out valid
- rd_data_out  out  DATA_W  registered read data, held until next read completes
- busy  out  1  high from the cycle after an accepted start through the done cycle
- ram_addr  out  ADDR_W  RAM address (registered)
- ram_data  out  DATA_W  RAM write data (registered)
- ram_wren  out  1  RAM write enable (registered)
- ram_q  in  DATA_W  RAM read data
- proto_err  out  1  sticky protocol-violation flag (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): state IDLE; wr_done, rd_done, ram_wren, busy, proto_err = 0; ram_addr, ram_data, rd_data_out = 0.
- States: IDLE, WR_EXEC, WR_ACK, RD_ADDR, RD_WAIT, RD_ACK. busy = (state != IDLE).
- IDLE, wr_start (cycle 0):
  - Latch addr_in to ram_addr and wr_data_in to ram_data.
  - Set ram_wren, go to WR_EXEC.
- WR_EXEC (cycle 1): ram_wren high this cycle only; clear it; go to WR_ACK.
- WR_ACK (cycle 2): wr_done = 1; return to IDLE. Write latency is 2 cycles, start to done.
- IDLE, rd_start (cycle 0): latch addr_in to ram_addr; go to RD_ADDR.
- RD_ADDR (cycle 1): load wait counter with RD_LAT-1; go to RD_WAIT.
- RD_WAIT: decrement the counter. When it reaches 0, capture ram_q into rd_data_out and go to RD_ACK. With RD_LAT=1, capture occurs on the first RD_WAIT cycle.
- RD_ACK: rd_done = 1; return to IDLE. Read latency is RD_LAT+2 cycles, start to done (3 with the default).
- Next request may be accepted in the cycle immediately after the done cycle. A start coincident with done is ignored.
- Simultaneous wr_start and rd_start in IDLE: write wins; read is dropped (no rd_done).
- Starts while busy are ignored; the in-flight operation is unaffected.
- ram_wren is never high outside WR_EXEC; ram_addr and ram_data hold their values between requests.
- Address wrap: none internal; the full 0..255 range is legal.
- Reset mid-operation: abort immediately. No done pulse is issued, and ram_wren drops asynchronously.
- Done outputs and ram_wren come straight from registered state or flags (glitch-free).

Optional Feature:
- Macro: S_MEM_PROTOCOL_CHECK_EN.
- Defined: proto_err sets, and stays set until reset, on any of:
  - wr_start and rd_start high together
  - any start while busy
  - start coincident with a done pulse
- Behaviour of the data path is unchanged.
- Not defined: proto_err is tied to 0, and no checking logic is synthesized.

Decomposition:
- Shared package s_mem_pkg holds:
  - state enum typedef
  - ADDR_W/DATA_W defaults
  - S-array depth constant (256)
- Optional sub-module s_mem_lat_counter: a small load/decrement down-counter that flags zero, used in RD_WAIT.
- Everything else stays in one module.

Test Plan:
- After reset, wr_start with addr_in=0x2A, wr_data_in=0x5C at cycle 0 -> ram_wren=1 only at cycle 1 with ram_addr=0x2A, ram_data=0x5C; wr_done pulse at cycle 2; busy high cycles 1-2.
- Write 0x5C to 0x2A, then rd_start addr 0x2A (RAM model RD_LAT=1) -> rd_done at start+3, rd_data_out=0x5C held until the next read; repeat with RD_LAT=3 -> rd_done at start+5.
- Sequential sweep: 256 back-to-back writes s[i]=i, each issued the cycle after wr_done -> exactly 256 wr_done pulses; 256 reads return i at address i, including 0x00 and 0xFF.
- wr_start and rd_start together (addr 0x10, data 0xAA) -> only a write occurs, wr_done at +2, no rd_done; with S_MEM_PROTOCOL_CHECK_EN, proto_err=1 and sticky.
- rd_start pulsed again at cycle 1 of a read -> ignored, exactly one rd_done; with the macro on, proto_err=1; without it, proto_err stays 0.
- Assert reset during WR_EXEC -> ram_wren drops immediately, no wr_done, busy=0; after release, a fresh write to 0x01 completes normally.
